mem_rmw_ctrl: RTL
=================

# mem_rmw_ctrl

Parametrised successor of the single-port memory controller: one request/response channel for loads and stores of 1, 2, 4 or 8 bytes to a synchronous-read RAM with no byte enables. Checks alignment, address range and access size, performs read-modify-write for sub-word stores, and sign- or zero-extends loads to DATA_W. Sits between the core's load/store unit and the data RAM macro.

## Interface

Parameters:
- DATA_W, 32: RAM word width in bits; 32 or 64. BPW = DATA_W/8 and OFS_W = log2(BPW).
- MAP_ZERO, 0: byte address of RAM word 0.
- MAP_SIZE, 'h10000: mapped bytes; power of two, multiple of BPW.
- MEM_AW, $clog2(MAP_SIZE/BPW): RAM word-address width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_sext_i  in  1  sign-extend load result.
- req_acc_i  in  2  size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  DATA_W  store data, right-aligned.
- rsp_valid_o  out  1  response valid; held until rsp_ready_i.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err_o  out  2  0 = ok, 1 = misaligned, 2 = out of range, 3 = unsupported size.
- mem_en_o  out  1  RAM access this cycle.
- mem_we_o  out  1  RAM write; meaningful only with mem_en_o.
- mem_addr_o  out  MEM_AW  RAM word address.
- mem_wdata_o  out  DATA_W  RAM write data.
- mem_rdata_i  in  DATA_W  RAM read data, valid the cycle after a read.

## Operation

- States: RESET, IDLE, RD_WAIT, RMW_WAIT, RESP. Reset enters RESET; RESET goes to IDLE unconditionally after one cycle.
- req_ready_o = (state == IDLE). The request is registered on acceptance. Request inputs are ignored in every other cycle.
- Checks are combinational in the accept cycle, in priority order:
  - acc = 3 with DATA_W = 32 gives err 3.
  - addr not a multiple of 2^acc gives err 1.
  - addr < MAP_ZERO, or addr - MAP_ZERO >= MAP_SIZE, gives err 2.
  - On any error: no RAM access; go to RESP.
- Offsets: off = (addr - MAP_ZERO)[OFS_W-1:0]; mem_addr_o = (addr - MAP_ZERO) >> OFS_W.
- Load: assert mem_en_o=1, mem_we_o=0 in the accept cycle and go to RD_WAIT. In RD_WAIT:
  - take 8·2^acc bits of mem_rdata_i starting at bit 8·off;
  - sign- or zero-extend to DATA_W per the registered sext, into rsp_rdata;
  - go to RESP.
- Full-width store (2^acc == BPW): assert mem_en_o=1, mem_we_o=1, mem_wdata_o = wdata in the accept cycle; go to RESP.
- Sub-word store: issue a RAM read in the accept cycle and go to RMW_WAIT. In RMW_WAIT:
  - assert mem_en_o=1, mem_we_o=1 at the registered word address;
  - mem_wdata_o = mem_rdata_i with bytes [off, off+2^acc) replaced by the low 2^acc bytes of wdata;
  - go to RESP.
- RESP: rsp_valid_o=1. On rsp_ready_i go to IDLE next cycle; otherwise hold rsp_rdata_o and rsp_err_o stable.
- mem_* outputs are 0 whenever mem_en_o is 0.
- Any state encoding not listed returns to IDLE.

## Timing

- All outputs are 0 in reset and in RESET. req_ready_o rises the first cycle after reset release plus one.
- Request accepted in cycle T; rsp_valid_o rises at:
  - T+1 for errors and full-width stores;
  - T+2 for loads and sub-word stores.
- The RMW write is issued at T+1.
- Completion with rsp_ready_i=1 in the first RESP cycle: next request is accepted no earlier than T+2 (errors and full stores) or T+3 (loads and sub-word stores).
- rsp_ready_i asserted while rsp_valid_o=0 has no effect.
- mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o are combinational from state and request; the RAM samples them at the clock edge.
- Asynchronous reset mid-operation forces RESET immediately: mem_en_o drops at once, the pending request and response are discarded, and no write of a pending RMW occurs.

## Test plan

- DATA_W=32, MAP_ZERO=0: RAM[1]='h11223344. Byte store 'hAB to addr 6 gives RAM[1]='h11AB3344, err 0, rsp_valid_o at T+2, write issued at T+1.
- DATA_W=32: signed byte load from addr 7 with RAM[1]='h80000000 gives rsp_rdata_o='hFFFFFF80. Unsigned half load from addr 6 gives 'h00008000.
- DATA_W=64: dword store 'h0123456789ABCDEF to addr 8 is a single write at T and rsp_valid_o at T+1. Word load from addr 12 then returns 'h0000000001234567.
- Errors: half load addr 3 gives err 1; word load addr MAP_SIZE gives err 2; dword with DATA_W=32 gives err 3 (size wins over misaligned at addr 3). No mem_en_o in any case; rsp_valid_o at T+1.
- Backpressure: rsp_ready_i held low 5 cycles gives rsp_valid_o and rsp_rdata_o stable, req_ready_o=0, no RAM activity; completion one cycle after rsp_ready_i.
- Reset asserted in RMW_WAIT gives no RAM write, all outputs 0, req_ready_o=1 two cycles after release; RAM contents unchanged.

Source files
------------

// File: rtl/mem_rmw_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_rmw_ctrl : load/store front end for a RAM without byte enables.
// Sub-word stores use read-modify-write; loads are sign/zero extended. Rev 1.0
// ---------------------------------------------------------------------------
module mem_rmw_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [31:0] MAP_ZERO = 32'h0,
  parameter logic [32:0] MAP_SIZE = 33'h10000,
  parameter int unsigned MEM_AW   = $clog2(MAP_SIZE / (DATA_W / 8))
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic              req_sext_i,
  input  logic [1:0]        req_acc_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int unsigned BPW   = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(BPW);

  localparam logic [2:0] S_RESET    = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_RMW_WAIT = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              sext_q, sext_d;
  logic [1:0]        acc_q, acc_d;
  logic [OFS_W-1:0]  off_q, off_d;
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  logic [31:0]       rel_addr;
  logic              misalign;
  logic              out_of_range;
  logic              full_w;
  logic [1:0]        chk_err;

  assign rel_addr     = req_addr_i - MAP_ZERO;
  assign out_of_range = (req_addr_i < MAP_ZERO) || ({1'b0, rel_addr} >= MAP_SIZE);
  assign full_w       = (4'd1 << req_acc_i) == 4'(BPW);

  always_comb begin
    case (req_acc_i)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr_i[0];
      2'd2:    misalign = |req_addr_i[1:0];
      default: misalign = |req_addr_i[2:0];
    endcase
  end

  always_comb begin
    if ((req_acc_i == 2'd3) && (DATA_W == 32)) chk_err = 2'd3;
    else if (misalign)                         chk_err = 2'd1;
    else if (out_of_range)                     chk_err = 2'd2;
    else                                       chk_err = 2'd0;
  end

  // Lane handling: shift the selected bytes to bit 0 (loads) or into place
  // (stores); pad is how many bits lie above the accessed lane.
  logic [7:0]          sel_bits;
  logic [7:0]          pad;
  logic [OFS_W+2:0]    bit_ofs;
  logic [DATA_W-1:0]   rd_shift, rd_left, rd_ext;
  logic [DATA_W-1:0]   lane_mask, wr_shift, rmw_word;

  assign sel_bits  = 8'd8 << acc_q;
  assign pad       = 8'(DATA_W) - sel_bits;
  assign bit_ofs   = {off_q, 3'b000};
  assign rd_shift  = mem_rdata_i >> bit_ofs;
  assign rd_left   = rd_shift << pad;
  assign rd_ext    = sext_q ? $unsigned($signed(rd_left) >>> pad) : (rd_left >> pad);
  assign lane_mask = ({DATA_W{1'b1}} >> pad) << bit_ofs;
  assign wr_shift  = wdata_q << bit_ofs;
  assign rmw_word  = (mem_rdata_i & ~lane_mask) | (wr_shift & lane_mask);

  always_comb begin
    state_d     = state_q;
    sext_d      = sext_q;
    acc_d       = acc_q;
    off_d       = off_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        if (req_valid_i) begin
          sext_d  = req_sext_i;
          acc_d   = req_acc_i;
          off_d   = rel_addr[OFS_W-1:0];
          waddr_d = rel_addr[OFS_W +: MEM_AW];
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = chk_err;
          if (chk_err != 2'd0) begin
            state_d = S_RESP;
          end else begin
            mem_en_o   = 1'b1;
            mem_addr_o = rel_addr[OFS_W +: MEM_AW];
            if (req_we_i && full_w) begin
              mem_we_o    = 1'b1;
              mem_wdata_o = req_wdata_i;
              state_d     = S_RESP;
            end else if (req_we_i) begin
              state_d = S_RMW_WAIT;
            end else begin
              state_d = S_RD_WAIT;
            end
          end
        end
      end
      S_RD_WAIT: begin
        rdata_d = rd_ext;
        state_d = S_RESP;
      end
      S_RMW_WAIT: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = waddr_q;
        mem_wdata_o = rmw_word;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_RESET;
      sext_q  <= 1'b0;
      acc_q   <= 2'd0;
      off_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sext_q  <= sext_d;
      acc_q   <= acc_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o ? err_q : 2'd0;

endmodule
`default_nettype wire
